// File: rtl/ksa_swap_responder.sv
// ksa_swap_responder: S-memory responder for the RC4 KSA initiator.
// Serves level-sensitive reads of S[i] and edge-triggered S[i]<->S[j] swaps
// against a single-port RAM with a registered address and one cycle of read latency.
module ksa_swap_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              ask_i,
    input  logic [ADDR_W-1:0] i_a,
    input  logic [ADDR_W-1:0] j_a,
    input  logic              start_swapping,
    output logic [DATA_W-1:0] data_i,
    output logic              finish_swapping,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [3:0] {
        StIdle,
        StRdWait,
        StRdCap,
        StSwRi,
        StSwRj,
        StSwCj,
        StSwWj,
        StSwDone,
        StSwAck
    } state_e;

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_i, w_i_d;
    logic [ADDR_W-1:0]   r_j, w_j_d;
    logic [DATA_W-1:0]   r_si, w_si_d;
    logic                r_start_prev;
    logic                r_pending, w_pending_d;
    logic [DATA_W-1:0]   r_data, w_data_d;
    logic                r_finish, w_finish_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_wdata, w_wdata_d;
    logic                r_wren, w_wren_d;
    logic                w_start_rise;
    logic                w_busy;

    assign w_start_rise = start_swapping & ~r_start_prev;
    assign w_busy       = (r_state != StIdle);

    assign data_i          = r_data;
    assign finish_swapping = r_finish;
    assign busy            = w_busy;
    assign mem_address     = r_addr;
    assign mem_data        = r_wdata;
    assign mem_wren        = r_wren;

    // State and datapath registers; reset aborts any operation, clearing write enable at once.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_i          <= '0;
            r_j          <= '0;
            r_si         <= '0;
            r_start_prev <= 1'b0;
            r_pending    <= 1'b0;
            r_data       <= '0;
            r_finish     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wren       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_i          <= w_i_d;
            r_j          <= w_j_d;
            r_si         <= w_si_d;
            r_start_prev <= start_swapping;
            r_pending    <= w_pending_d;
            r_data       <= w_data_d;
            r_finish     <= w_finish_d;
            r_addr       <= w_addr_d;
            r_wdata      <= w_wdata_d;
            r_wren       <= w_wren_d;
        end
    end

    // Next-state and registered-output decode; swap requests outrank reads in IDLE.
    always_comb begin
        w_state_d   = r_state;
        w_i_d       = r_i;
        w_j_d       = r_j;
        w_si_d      = r_si;
        // A rising start seen while busy is remembered until the next IDLE cycle.
        w_pending_d = r_pending | (w_start_rise & w_busy);
        w_data_d    = r_data;
        w_finish_d  = r_finish;
        w_addr_d    = r_addr;
        w_wdata_d   = r_wdata;
        w_wren_d    = r_wren;

        case (r_state)
            StIdle: begin
                if (w_start_rise || r_pending) begin
                    w_pending_d = 1'b0;
                    w_i_d       = i_a;
                    w_j_d       = j_a;
                    w_addr_d    = i_a;
                    w_state_d   = StSwRi;
                end else if (ask_i) begin
                    w_addr_d  = i_a;
                    w_state_d = StRdWait;
                end
            end
            StRdWait: begin
                w_state_d = StRdCap;
            end
            StRdCap: begin
                w_data_d  = mem_q;
                w_state_d = StIdle;
            end
            StSwRi: begin
                w_addr_d  = r_j;
                w_state_d = StSwRj;
            end
            StSwRj: begin
                // mem_q now holds S[i] from the address issued in IDLE.
                w_si_d    = mem_q;
                w_state_d = StSwCj;
            end
            StSwCj: begin
                // mem_q now holds S[j]; write it straight to S[i].
                w_addr_d  = r_i;
                w_wdata_d = mem_q;
                w_wren_d  = 1'b1;
                w_state_d = StSwWj;
            end
            StSwWj: begin
                w_addr_d  = r_j;
                w_wdata_d = r_si;
                w_wren_d  = 1'b1;
                w_state_d = StSwDone;
            end
            StSwDone: begin
                w_wren_d   = 1'b0;
                w_finish_d = 1'b1;
                w_state_d  = StSwAck;
            end
            StSwAck: begin
                w_finish_d = 1'b0;
                w_state_d  = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_ksa_swap_responder.sv
// tb_ksa_swap_responder: directed and randomized checks of the KSA swap responder
// against a RAM model and an array-level reference of S.
module tb_ksa_swap_responder;

    logic       clk;
    logic       rst;
    logic       ask;
    logic [7:0] ia;
    logic [7:0] ja;
    logic       start;
    logic [7:0] data;
    logic       finish;
    logic       bsy;
    logic [7:0] maddr;
    logic [7:0] mdata;
    logic       mwren;
    logic [7:0] mq;

    logic [7:0] ram [256];
    logic [7:0] ram_addr_q;
    logic [7:0] ref_mem [256];

    int n_vec = 0;
    int n_err = 0;

    ksa_swap_responder #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (rst),
        .ask_i          (ask),
        .i_a            (ia),
        .j_a            (ja),
        .start_swapping (start),
        .data_i         (data),
        .finish_swapping(finish),
        .busy           (bsy),
        .mem_address    (maddr),
        .mem_data       (mdata),
        .mem_wren       (mwren),
        .mem_q          (mq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered address, write on the edge, read data one cycle later.
    always @(posedge clk) begin
        if (mwren) ram[maddr] <= mdata;
        ram_addr_q <= maddr;
    end
    assign mq = ram[ram_addr_q];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read S[ri]; DUT must be idle on entry and is idle again on return.
    task automatic do_read(input logic [7:0] ri);
        int nw;
        ask = 1'b1;
        ia  = ri;
        step();  // E0
        check_eq("rd_busy_e0", 32'(bsy), 1);
        check_eq("rd_addr_e0", 32'(maddr), 32'(ri));
        nw  = int'(mwren);
        ask = 1'b0;
        ia  = 8'($urandom);
        step();  // E1
        check_eq("rd_busy_e1", 32'(bsy), 1);
        nw += int'(mwren);
        step();  // E2
        nw += int'(mwren);
        check_eq("rd_data", 32'(data), 32'(ref_mem[ri]));
        check_eq("rd_no_wren", 32'(nw), 0);
    endtask

    // Swap S[si]<->S[sj] with edge-accurate checks; indices are scrambled after E0.
    task automatic do_swap(input logic [7:0] si, input logic [7:0] sj, input bit hold_start);
        logic [7:0] vi, vj;
        int nw, nf;
        vi    = ref_mem[si];
        vj    = ref_mem[sj];
        start = 1'b1;
        ia    = si;
        ja    = sj;
        step();  // E0
        check_eq("sw_busy_e0", 32'(bsy), 1);
        check_eq("sw_addr_e0", 32'(maddr), 32'(si));
        if (!hold_start) start = 1'b0;
        ia = 8'($urandom);
        ja = 8'($urandom);
        nw = 0;
        nf = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            nw += int'(mwren);
            nf += int'(finish);
            if (e == 3) begin
                check_eq("sw_waddr_i", 32'(maddr), 32'(si));
                check_eq("sw_wdata_i", 32'(mdata), 32'(vj));
            end
            if (e == 4) begin
                check_eq("sw_waddr_j", 32'(maddr), 32'(sj));
                check_eq("sw_wdata_j", 32'(mdata), 32'(vi));
            end
            if (e == 5) check_eq("sw_finish_e5", 32'(finish), 1);
        end
        check_eq("sw_busy_e6", 32'(bsy), 0);
        check_eq("sw_wren_cycles", 32'(nw), 2);
        check_eq("sw_finish_cycles", 32'(nf), 1);
        ref_mem[si] = vj;
        ref_mem[sj] = vi;
    endtask

    initial begin
        int nw, nf;
        logic [7:0] ri, rj;

        for (int k = 0; k < 256; k++) begin
            ram[k]     = 8'(k);
            ref_mem[k] = 8'(k);
        end
        ram_addr_q = 8'h00;
        rst   = 1'b1;
        ask   = 1'b0;
        ia    = 8'h00;
        ja    = 8'h00;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Idle after reset: outputs stay at zero, no writes.
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            nw += int'(mwren);
        end
        check_eq("rst_data", 32'(data), 0);
        check_eq("rst_finish", 32'(finish), 0);
        check_eq("rst_busy", 32'(bsy), 0);
        check_eq("rst_addr", 32'(maddr), 0);
        check_eq("rst_mdata", 32'(mdata), 0);
        check_eq("rst_wren_cycles", 32'(nw), 0);

        do_read(8'h10);

        do_swap(8'd3, 8'd200, 1'b0);
        check_eq("ram3", 32'(ram[3]), 200);
        check_eq("ram200", 32'(ram[200]), 3);

        // i == j, then a held start must not retrigger.
        do_swap(8'd7, 8'd7, 1'b1);
        check_eq("ram7", 32'(ram[7]), 7);
        nw = 0;
        nf = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            nw += int'(mwren);
            nf += int'(finish);
        end
        check_eq("hold_no_wren", 32'(nw), 0);
        check_eq("hold_no_finish", 32'(nf), 0);
        start = 1'b0;
        step();

        // Swap requested during a read with ask held high: swap goes next, then reads resume.
        ask = 1'b1;
        ia  = 8'd20;
        step();  // read E0
        start = 1'b1;
        ia    = 8'd30;
        ja    = 8'd40;
        step();
        step();
        check_eq("pend_rd_data", 32'(data), 32'(ref_mem[20]));
        step();  // swap E0
        check_eq("pend_sw_addr", 32'(maddr), 30);
        ia = 8'd50;
        ja = 8'd60;
        nw = 0;
        nf = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            nw += int'(mwren);
            nf += int'(finish);
        end
        check_eq("pend_wren_cycles", 32'(nw), 2);
        check_eq("pend_finish_cycles", 32'(nf), 1);
        ri          = ref_mem[30];
        ref_mem[30] = ref_mem[40];
        ref_mem[40] = ri;
        step();  // read resumes with the new i_a
        check_eq("resume_addr", 32'(maddr), 50);
        ask = 1'b0;
        step();
        step();
        check_eq("resume_data", 32'(data), 32'(ref_mem[50]));
        check_eq("ram30", 32'(ram[30]), 32'(ref_mem[30]));
        check_eq("ram40", 32'(ram[40]), 32'(ref_mem[40]));
        start = 1'b0;
        step();

        // Reset after the first write of a 1<->2 swap: second write never lands.
        start = 1'b1;
        ia    = 8'd1;
        ja    = 8'd2;
        step();  // E0
        start = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        rst = 1'b1;
        #1;
        check_eq("abort_wren", 32'(mwren), 0);
        check_eq("abort_busy", 32'(bsy), 0);
        check_eq("abort_finish", 32'(finish), 0);
        check_eq("abort_addr", 32'(maddr), 0);
        check_eq("abort_mdata", 32'(mdata), 0);
        check_eq("abort_data", 32'(data), 0);
        step();
        rst = 1'b0;
        step();
        check_eq("abort_ram1", 32'(ram[1]), 2);
        check_eq("abort_ram2", 32'(ram[2]), 2);
        ref_mem[1] = 8'd2;
        do_swap(8'd1, 8'd9, 1'b0);

        // Randomized mix of reads and swaps.
        for (int n = 0; n < 40; n++) begin
            ri = 8'($urandom);
            rj = 8'($urandom);
            if ($urandom_range(0, 1) == 0) do_read(ri);
            else do_swap(ri, rj, 1'b0);
        end

        for (int k = 0; k < 256; k++) check_eq("final_ram", 32'(ram[k]), 32'(ref_mem[k]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
